// File: rtl/bram_epp_reader_if.sv
// EPP host port plus BRAM read port of the read-back engine.
// master = host/BRAM side, slave = bram_epp_reader.
interface bram_epp_reader_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) ();
   logic              dataStb;
   logic [1:0]        addrEpp;
   logic              eppWrite;
   logic [DATA_W-1:0] busEppIn;
   logic [DATA_W-1:0] busEppOut;
   logic              eppWait;
   logic [ADDR_W-1:0] busBramAddr;
   logic              bramEn;
   logic [DATA_W-1:0] busBramIn;

   // Handshake: host drops dataStb and holds addrEpp/eppWrite/busEppIn steady;
   // eppWait high means busEppOut is valid (read) or the write was taken, and
   // it stays high until the host raises dataStb again.
   modport master (
      output dataStb, addrEpp, eppWrite, busEppIn, busBramIn,
      input  busEppOut, eppWait, busBramAddr, bramEn
   );

   modport slave (
      input  dataStb, addrEpp, eppWrite, busEppIn, busBramIn,
      output busEppOut, eppWait, busBramAddr, bramEn
   );
endinterface

// File: rtl/bram_epp_reader.sv
// EPP read-back engine: host sets a BRAM address, then streams bytes out via reg 2.
// Optional READBACK_CRC_EN: reg 3 returns a running CRC-8 of delivered bytes.
module bram_epp_reader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   bram_epp_reader_if.slave     bus,
   output logic [1:0]           state_dbg
);

   localparam int HI_W = ADDR_W - 8;

   typedef enum logic [1:0] {IDLE, FETCH, LATCH, HOLD} state_t;

   state_t            state, state_nxt;
   logic              s1, s2, s3;
   logic              strobe_start;
   logic [1:0]        sel_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr;
   logic              do_latch, do_release;
   logic              bram_en, epp_wait;
   logic              inc_addr, clear_reg0;
   logic [DATA_W-1:0] status_byte;
   logic [DATA_W-1:0] rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= bus.dataStb;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign strobe_start = ~s2 & s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      bram_en    = 1'b0;
      epp_wait   = 1'b0;
      do_latch   = 1'b0;
      do_release = 1'b0;
      case (state)
         IDLE:  if (strobe_start) state_nxt = FETCH;
         FETCH: begin
            bram_en   = 1'b1;
            state_nxt = LATCH;
         end
         LATCH: begin
            do_latch  = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            epp_wait = 1'b1;
            // an early release is seen here too, so HOLD still lasts one cycle
            if (s2) begin
               do_release = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.bramEn      = bram_en;
   assign bus.eppWait     = epp_wait;
   assign bus.busBramAddr = addr;
   assign state_dbg       = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q <= 2'd0;
         wr_q  <= 1'b0;
      end else if (state == IDLE && strobe_start) begin
         sel_q <= bus.addrEpp;
         wr_q  <= bus.eppWrite;
      end
   end

   assign inc_addr   = do_release & ~wr_q & (sel_q == 2'd2);
   assign clear_reg0 = do_latch & wr_q & (sel_q == 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr <= '0;
      end else if (do_latch && wr_q) begin
         if (sel_q == 2'd0) addr[7:0]        <= bus.busEppIn[7:0];
         if (sel_q == 2'd1) addr[ADDR_W-1:8] <= bus.busEppIn[HI_W-1:0];
      end else if (inc_addr) begin
         addr <= addr + 1'b1;
      end
   end

`ifdef READBACK_CRC_EN
   logic [7:0] crc;

   function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++)
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         crc <= 8'h00;
      else if (clear_reg0)
         crc <= 8'h00;
      else if (do_latch && !wr_q && sel_q == 2'd2)
         crc <= crc8_next(crc, bus.busBramIn[7:0]);
   end

   assign status_byte = DATA_W'(crc);
`else
   logic wrap;

   // sticky until the host rewrites the low address byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wrap <= 1'b0;
      else if (clear_reg0)
         wrap <= 1'b0;
      else if (inc_addr && (&addr))
         wrap <= 1'b1;
   end

   assign status_byte = DATA_W'(wrap);
`endif

   always_comb begin
      rd_data = '0;
      case (sel_q)
         2'd0:    rd_data = DATA_W'(addr[7:0]);
         2'd1:    rd_data = DATA_W'(addr[ADDR_W-1:8]);
         2'd2:    rd_data = bus.busBramIn;
         default: rd_data = status_byte;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bus.busEppOut <= '0;
      else if (do_latch && !wr_q)
         bus.busEppOut <= rd_data;
   end

endmodule

// File: tb/tb_bram_epp_reader.sv
// Bench for bram_epp_reader: table vectors, handshake/reset sequences and a
// random phase checked against a register-level model of the host-visible map.
module tb_bram_epp_reader;

   logic       clk;
   logic       rst;
   logic [1:0] state_dbg;

   bram_epp_reader_if #(.ADDR_W(12), .DATA_W(8)) bus ();

   bram_epp_reader #(.ADDR_W(12), .DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   logic [7:0] mem [4096];
   int         bram_cnt = 0;

   always @(posedge clk) begin
      if (bus.bramEn === 1'b1) begin
         bus.busBramIn <= mem[bus.busBramAddr];
         bram_cnt++;
      end
   end

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // host-visible model: address, wrap flag, CRC
   int         m_addr = 0;
   bit         m_wrap = 0;
   logic [7:0] m_crc  = 8'h00;

   function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++)
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
   endfunction

   function automatic logic [7:0] model_step(input logic [1:0] sel, input logic wr, input logic [7:0] din);
      logic [7:0] d;
      d = 8'h00;
      if (wr) begin
         if (sel == 0) begin
            m_addr = (m_addr / 256) * 256 + din;
            m_wrap = 0;
            m_crc  = 8'h00;
         end else if (sel == 1) begin
            m_addr = (din % 16) * 256 + (m_addr % 256);
         end
      end else begin
         case (sel)
            0: d = 8'(m_addr % 256);
            1: d = 8'(m_addr / 256);
            2: begin
               d     = mem[m_addr];
               m_crc = crc8(m_crc, d);
               if (m_addr == 4095) m_wrap = 1;
               m_addr = (m_addr + 1) % 4096;
            end
            default: begin
`ifdef READBACK_CRC_EN
               d = m_crc;
`else
               d = {7'b0, m_wrap};
`endif
            end
         endcase
      end
      return d;
   endfunction

   task automatic do_cycle(input logic [1:0] sel, input logic wr, input logic [7:0] din,
                           output logic [7:0] dout, output logic [7:0] exp);
      int b0;
      bit got;
      b0 = bram_cnt;
      bus.addrEpp  = sel;
      bus.eppWrite = wr;
      bus.busEppIn = din;
      bus.dataStb  = 1'b0;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.eppWait === 1'b1) begin got = 1; break; end
      end
      check("wait_rise", 32'(got), 1);
      dout = bus.busEppOut;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.dataStb = 1'b1;
      got = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.eppWait === 1'b0) begin got = 1; break; end
      end
      check("wait_fall", 32'(got), 1);
      exp = model_step(sel, wr, din);
      check("bram_en_pulses", 32'(bram_cnt - b0), 1);
      check("bram_addr", 32'(bus.busBramAddr), 32'(m_addr));
   endtask

   typedef struct {
      logic [1:0] sel;
      logic       wr;
      logic [7:0] din;
      logic       chk;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [1:0] sel, input logic wr, input logic [7:0] din,
                               input logic chk, input logic [7:0] exp);
      vec_t v;
      v.sel = sel; v.wr = wr; v.din = din; v.chk = chk; v.exp = exp;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [7:0] dout, exp, st_wrap, st_c1, st_c2;
      int         t0, n;
      bit         got;

      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      mem[12'h038] = 8'hA5;
      mem[12'h039] = 8'h5A;
      mem[12'hFFF] = 8'h3C;
      mem[12'h000] = 8'hC3;
      mem[12'h040] = 8'h01;
      mem[12'h041] = 8'h00;

`ifdef READBACK_CRC_EN
      st_wrap = crc8(crc8(8'h00, 8'h3C), 8'hC3);
      st_c1   = 8'h07;
      st_c2   = 8'h15;
`else
      st_wrap = 8'h01;
      st_c1   = 8'h00;
      st_c2   = 8'h00;
`endif

      // clock/reset
      rst          = 1'b1;
      bus.dataStb  = 1'b1;
      bus.addrEpp  = 2'd0;
      bus.eppWrite = 1'b0;
      bus.busEppIn = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_eppWait", 32'(bus.eppWait), 0);
      check("rst_busEppOut", 32'(bus.busEppOut), 0);
      check("rst_busBramAddr", 32'(bus.busBramAddr), 0);
      check("rst_bramEn", 32'(bus.bramEn), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // register-map vectors
      add(0, 1, 8'h38, 0, 8'h00); add(1, 1, 8'h00, 0, 8'h00);
      add(2, 0, 8'h00, 1, 8'hA5); add(2, 0, 8'h00, 1, 8'h5A);
      add(2, 1, 8'h77, 0, 8'h00);
      add(0, 0, 8'h00, 1, 8'h3A); add(1, 0, 8'h00, 1, 8'h00);
      add(0, 1, 8'h14, 0, 8'h00); add(1, 1, 8'h24, 0, 8'h00);
      add(0, 0, 8'h00, 1, 8'h14); add(1, 0, 8'h00, 1, 8'h04);
      add(3, 0, 8'h00, 1, 8'h00);
      add(0, 1, 8'hFF, 0, 8'h00); add(1, 1, 8'h0F, 0, 8'h00);
      add(2, 0, 8'h00, 1, 8'h3C); add(2, 0, 8'h00, 1, 8'hC3);
      add(3, 0, 8'h00, 1, st_wrap);
      add(0, 0, 8'h00, 1, 8'h01); add(1, 0, 8'h00, 1, 8'h00);
      add(0, 1, 8'h00, 0, 8'h00); add(3, 0, 8'h00, 1, 8'h00);
      add(0, 1, 8'h40, 0, 8'h00); add(1, 1, 8'h00, 0, 8'h00);
      add(2, 0, 8'h00, 1, 8'h01); add(3, 0, 8'h00, 1, st_c1);
      add(2, 0, 8'h00, 1, 8'h00); add(3, 0, 8'h00, 1, st_c2);

      foreach (tbl[i]) begin
         do_cycle(tbl[i].sel, tbl[i].wr, tbl[i].din, dout, exp);
         if (tbl[i].chk) check($sformatf("vec%0d", i), 32'(dout), 32'(tbl[i].exp));
      end

      // handshake timing: 200 ns strobe on reg 0 read
      bus.addrEpp  = 2'd0;
      bus.eppWrite = 1'b0;
      bus.dataStb  = 1'b0;
      t0 = int'($time);
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk); #1;
         if (e == 3) check("hs_bramEn_e3", 32'(bus.bramEn), 1);
         if (e == 4) begin
            check("hs_bramEn_e4", 32'(bus.bramEn), 0);
            check("hs_wait_e4", 32'(bus.eppWait), 0);
         end
         if (e == 5) check("hs_wait_e5", 32'(bus.eppWait), 1);
      end
      exp = model_step(2'd0, 1'b0, 8'h00);
      check("hs_data", 32'(bus.busEppOut), 32'(exp));
      #(t0 + 200 - int'($time));
      bus.dataStb = 1'b1;
      n = 0;
      for (int e = 1; e <= 6; e++) begin
         @(posedge clk); #1;
         if (bus.eppWait === 1'b0) begin n = e; break; end
      end
      check("hs_release_edges", 32'(n >= 2 && n <= 3), 1);
      @(negedge clk);

      // reset while eppWait is high
      do_cycle(0, 1, 8'h10, dout, exp);
      bus.addrEpp  = 2'd2;
      bus.eppWrite = 1'b0;
      bus.dataStb  = 1'b0;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.eppWait === 1'b1) begin got = 1; break; end
      end
      check("rh_wait_rise", 32'(got), 1);
      #5 rst = 1'b1;
      #1;
      check("rh_eppWait", 32'(bus.eppWait), 0);
      check("rh_busEppOut", 32'(bus.busEppOut), 0);
      check("rh_busBramAddr", 32'(bus.busBramAddr), 0);
      @(negedge clk);
      bus.dataStb = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_addr = 0; m_wrap = 0; m_crc = 8'h00;
      repeat (2) @(negedge clk);
      do_cycle(2, 0, 8'h00, dout, exp);
      check("rh_next_read", 32'(dout), 32'(exp));
      check("rh_next_mem0", 32'(dout), 32'h0C3);

      // random traffic against the model
      for (int k = 0; k < 150; k++) begin
         logic [1:0] sel;
         logic       wr;
         logic [7:0] din;
         sel = 2'($urandom_range(0, 3));
         wr  = ($urandom_range(0, 3) == 0);
         din = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin sel = 2'd2; wr = 1'b0; end
         do_cycle(sel, wr, din, dout, exp);
         if (!wr) check($sformatf("rnd%0d_r%0d", k, sel), 32'(dout), 32'(exp));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_epp_reader.md
# bram_epp_reader

EPP read-back engine: lets the host PC fetch bytes from the sample BRAM over the same EPP data-strobe/register-select port that the capture path writes through. The host programs a 12-bit start address via two register writes, then issues data-strobe reads on the data register. Each read returns one BRAM byte and post-increments the address. The block sits between the EPP pins and the read port of the dual-port BRAM, opposite the EPP-to-BRAM write path.

## Interface
Parameters:
- ADDR_W, 12, BRAM address width
- DATA_W, 8, BRAM/EPP data width

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- dataStb  in  1  EPP data strobe, active-low, asynchronous to clk
- addrEpp  in  2  register select, sampled with dataStb
- eppWrite  in  1  1 = host write cycle, 0 = host read cycle
- busEppIn  in  DATA_W  host write data
- busEppOut  out  DATA_W  host read data
- eppWait  out  1  EPP wait/acknowledge; high = data valid / write taken
- busBramAddr  out  ADDR_W  BRAM read address
- bramEn  out  1  BRAM read enable
- busBramIn  in  DATA_W  BRAM read data; one-clk latency after bramEn

## Operation
- Register map (addrEpp): 0 = address[7:0] (W) / address[7:0] (R); 1 = address[11:8] from busEppIn[3:0] (W) / {4'b0, address[11:8]} (R); 2 = data port (R only, post-increment; writes ignored but still acknowledged); 3 = status (R): {7'b0, wrap}.
- dataStb passes through a 2-flop synchronizer (s1, s2) plus delay flop s3; strobe start = s2 low and s3 high.
- FSM states: IDLE, FETCH, LATCH, HOLD.
  - IDLE: on strobe start, capture addrEpp and eppWrite, go to FETCH.
  - FETCH: bramEn = 1 for exactly this cycle with busBramAddr = address; go to LATCH.
  - LATCH: load busEppOut (BRAM data for reg 2, register value otherwise); perform the write for write cycles; go to HOLD.
  - HOLD: eppWait = 1; when s2 is high, go to IDLE. On that transition, if the cycle was a reg-2 read, address increments.
- Address wraps 0xFFF to 0x000 on increment. The wrap flag is set on wrap and is sticky. A write to reg 0 clears it.
- Writes to reg 0 or 1 update only their own field.
- Reset values: busEppOut 0x00, eppWait 0, bramEn 0, busBramAddr 0x000, wrap 0, FSM IDLE, s1/s2/s3 high.

## Timing
- Edges are counted from the first rising clk edge that samples dataStb low (edge 1).
  - Edge 2: s2 low.
  - Edge 3: FSM enters FETCH.
  - Edge 4: enters LATCH.
  - Edge 5: enters HOLD, eppWait high, busEppOut valid.
- Strobe release: eppWait falls 2 or 3 edges after dataStb rises (synchronizer + one FSM edge). The incremented address appears on busBramAddr on that same edge.
- Strobe release before HOLD: the cycle completes normally and exits HOLD on its first cycle; a reg-2 read still counts.
- Strobe pulses shorter than 2 clk periods may be lost; no behaviour is required for them.
- A new strobe start is recognised only in IDLE. A strobe that falls during HOLD exit is taken on the next IDLE cycle, since s3 tracks s2.
- rst asserted mid-cycle returns everything to reset values immediately. The address is lost.
- busEppOut holds its last value between cycles.

## Configuration
- READBACK_CRC_EN defined:
  - A CRC-8 register (poly 0x07, MSB-first, init 0x00, no final XOR) updates with every byte delivered on reg 2, on the LATCH edge.
  - A write to reg 0 clears it.
  - Reg 3 reads return the CRC; the wrap flag is not readable.
- Undefined: no CRC logic; reg 3 returns the status byte.

## Test plan
- Set address: write 0x38 to reg 0 and 0x00 to reg 1, with BRAM model mem[0x038]=0xA5 and mem[0x039]=0x5A. Two reg-2 reads -> busEppOut 0xA5 then 0x5A; busBramAddr ends at 0x03A.
- Address readback: write 0x14 to reg 0 and 0x24 to reg 1 -> read reg 0 = 0x14, reg 1 = 0x04 (high nibble only), status = 0x00.
- Wrap: address 0xFFF, two reg-2 reads -> second read returns mem[0x000]; status reads 0x01. Writing reg 0 clears status to 0x00.
- Handshake: dataStb low for 200 ns at 20 ns clk -> eppWait high at edge 5, low within 3 edges of dataStb rising. bramEn is high for exactly one cycle per strobe.
- Reset mid-HOLD: assert rst while eppWait is high -> eppWait 0, busEppOut 0x00, busBramAddr 0x000 asynchronously; the next strobe operates normally.
- READBACK_CRC_EN: after a reg-0 write, read mem byte 0x01 -> reg 3 reads 0x07. Then read byte 0x00 -> reg 3 reads 0x15.
